// File: rtl/craps_round_ctrl.sv
// Craps round FSM: strobes both die stages, validates and sums faces, applies come-out/point rules.
// All outputs registered; a roll registers in one cycle, dice accepted from the cycle after roll_en.
module craps_round_ctrl #(
    parameter int TIMEOUT = 15
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       roll,
    input  logic [2:0] die_a,
    input  logic [2:0] die_b,
    input  logic       die_valid,
    output logic       roll_en,
    output logic [3:0] sum,
    output logic [3:0] point,
    output logic       win,
    output logic       lose,
    output logic       busy,
    output logic [2:0] state,
    output logic [7:0] rolls
);

    localparam int CW = $clog2(TIMEOUT + 2);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAIT_CO = 3'd1,
        POINT   = 3'd2,
        WAIT_PT = 3'd3,
        WON     = 3'd4,
        LOST    = 3'd5
    } state_t;

    state_t        cur, nxt;
    logic [CW-1:0] cnt;
    logic          fire;
    logic          accept;
    logic          new_round;
    logic          bad_face;
    logic          sample;
    logic [3:0]    dsum;

    assign dsum     = 4'(die_a) + 4'(die_b);
    assign bad_face = (die_a == 3'd0) || (die_a == 3'd7) || (die_b == 3'd0) || (die_b == 3'd7);
    // Faces coincident with the strobe are stale; only look once roll_en has dropped.
    assign sample   = die_valid && !roll_en;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            cur <= IDLE;
        end else begin
            cur <= nxt;
        end
    end

    always_comb begin
        nxt       = cur;
        fire      = 1'b0;
        accept    = 1'b0;
        new_round = 1'b0;
        case (cur)
            IDLE: begin
                if (roll) begin
                    fire = 1'b1;
                    nxt  = WAIT_CO;
                end
            end
            POINT: begin
                if (roll) begin
                    fire = 1'b1;
                    nxt  = WAIT_PT;
                end
            end
            WON, LOST: begin
                if (roll) begin
                    new_round = 1'b1;
                    fire      = 1'b1;
                    nxt       = WAIT_CO;
                end
            end
            WAIT_CO, WAIT_PT: begin
                if (sample) begin
                    if (bad_face) begin
                        fire = 1'b1;
                    end else begin
                        accept = 1'b1;
                        if (cur == WAIT_CO) begin
                            if (dsum == 4'd7 || dsum == 4'd11)
                                nxt = WON;
                            else if (dsum == 4'd2 || dsum == 4'd3 || dsum == 4'd12)
                                nxt = LOST;
                            else
                                nxt = POINT;
                        end else begin
                            if (dsum == point)
                                nxt = WON;
                            else if (dsum == 4'd7)
                                nxt = LOST;
                            else
                                nxt = POINT;
                        end
                    end
                end else if (!roll_en && cnt == CW'(TIMEOUT)) begin
                    fire = 1'b1;
                end
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            roll_en <= 1'b0;
            cnt     <= '0;
            sum     <= '0;
            point   <= '0;
            win     <= 1'b0;
            lose    <= 1'b0;
            rolls   <= '0;
        end else begin
            roll_en <= fire;
            if (fire)
                cnt <= '0;
            else if (cur == WAIT_CO || cur == WAIT_PT)
                cnt <= cnt + CW'(1);
            if (new_round) begin
                win   <= 1'b0;
                lose  <= 1'b0;
                point <= '0;
                rolls <= '0;
            end
            if (accept) begin
                sum <= dsum;
                if (rolls != 8'hFF)
                    rolls <= rolls + 8'd1;
                if (nxt == WON)
                    win <= 1'b1;
                if (nxt == LOST)
                    lose <= 1'b1;
                if (cur == WAIT_CO && nxt == POINT)
                    point <= dsum;
            end
        end
    end

    assign state = cur;
    assign busy  = (cur == WAIT_CO) || (cur == WAIT_PT);

endmodule

// File: tb/tb_craps_round_ctrl.sv
// Directed bench for craps_round_ctrl: hand-computed expectations checked with immediate assertions.
module tb_craps_round_ctrl;

    logic       clock = 1'b0;
    logic       resetn;
    logic       roll;
    logic [2:0] die_a;
    logic [2:0] die_b;
    logic       die_valid;
    logic       roll_en;
    logic [3:0] sum;
    logic [3:0] point;
    logic       win;
    logic       lose;
    logic       busy;
    logic [2:0] state;
    logic [7:0] rolls;

    int vectors = 0;
    int miscompares = 0;

    craps_round_ctrl #(.TIMEOUT(15)) dut (
        .clock(clock), .resetn(resetn), .roll(roll), .die_a(die_a), .die_b(die_b),
        .die_valid(die_valid), .roll_en(roll_en), .sum(sum), .point(point), .win(win),
        .lose(lose), .busy(busy), .state(state), .rolls(rolls)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Roll request; returns positioned in the roll_en cycle.
    task automatic press();
        roll = 1'b1;
        tick();
        roll = 1'b0;
    endtask

    // From the roll_en cycle: present faces one cycle later, return after the update edge.
    task automatic throw_dice(input logic [2:0] a, input logic [2:0] b);
        tick();
        die_a = a;
        die_b = b;
        die_valid = 1'b1;
        tick();
        die_valid = 1'b0;
    endtask

    task automatic chk_outcome(input string tag, input logic [3:0] s, input logic [3:0] p,
                               input logic w, input logic l, input logic [2:0] st,
                               input logic [7:0] r);
        chk({tag, ".sum"},   8'(sum),   8'(s));
        chk({tag, ".point"}, 8'(point), 8'(p));
        chk({tag, ".win"},   8'(win),   8'(w));
        chk({tag, ".lose"},  8'(lose),  8'(l));
        chk({tag, ".state"}, 8'(state), 8'(st));
        chk({tag, ".rolls"}, 8'(rolls), r);
    endtask

    task automatic chk_all_zero(input string tag);
        chk_outcome(tag, 4'd0, 4'd0, 1'b0, 1'b0, 3'd0, 8'd0);
        chk({tag, ".roll_en"}, 8'(roll_en), 8'd0);
        chk({tag, ".busy"},    8'(busy),    8'd0);
    endtask

    initial begin
        resetn = 1'b0; roll = 1'b0; die_a = 3'd0; die_b = 3'd0; die_valid = 1'b0;
        tick();
        tick();
        chk_all_zero("reset");
        resetn = 1'b1;
        tick();

        // Natural win
        press();
        chk("co.roll_en", 8'(roll_en), 8'd1);
        chk("co.busy",    8'(busy),    8'd1);
        chk("co.state",   8'(state),   8'd1);
        throw_dice(3'd3, 3'd4);
        chk_outcome("nat7", 4'd7, 4'd0, 1'b1, 1'b0, 3'd4, 8'd1);
        chk("nat7.busy", 8'(busy), 8'd0);

        // Point made
        press();
        chk("newround.win",   8'(win),   8'd0);
        chk("newround.rolls", 8'(rolls), 8'd0);
        throw_dice(3'd2, 3'd2);
        chk_outcome("pt4", 4'd4, 4'd4, 1'b0, 1'b0, 3'd2, 8'd1);
        press();
        chk("pt.state", 8'(state), 8'd3);
        throw_dice(3'd5, 3'd1);
        chk_outcome("pt6", 4'd6, 4'd4, 1'b0, 1'b0, 3'd2, 8'd2);
        press();
        throw_dice(3'd1, 3'd3);
        chk_outcome("ptmade", 4'd4, 4'd4, 1'b1, 1'b0, 3'd4, 8'd3);

        // Seven-out
        press();
        throw_dice(3'd5, 3'd5);
        chk_outcome("pt10", 4'd10, 4'd10, 1'b0, 1'b0, 3'd2, 8'd1);
        press();
        throw_dice(3'd6, 3'd1);
        chk_outcome("sevenout", 4'd7, 4'd10, 1'b0, 1'b1, 3'd5, 8'd2);
        press();
        chk("clr.lose",  8'(lose),  8'd0);
        chk("clr.point", 8'(point), 8'd0);
        chk("clr.rolls", 8'(rolls), 8'd0);
        chk("clr.state", 8'(state), 8'd1);

        // Craps on come-out
        throw_dice(3'd6, 3'd6);
        chk_outcome("craps12", 4'd12, 4'd0, 1'b0, 1'b1, 3'd5, 8'd1);
        press();
        throw_dice(3'd1, 3'd1);
        chk_outcome("craps2", 4'd2, 4'd0, 1'b0, 1'b1, 3'd5, 8'd1);

        // Roll during WAIT_CO, then invalid face, then timeout
        press();
        tick();
        chk("wait.roll_en", 8'(roll_en), 8'd0);
        roll = 1'b1;
        tick();
        roll = 1'b0;
        chk("extra_roll.roll_en", 8'(roll_en), 8'd0);
        chk("extra_roll.state",   8'(state),   8'd1);
        die_a = 3'd7; die_b = 3'd3; die_valid = 1'b1;
        tick();
        die_valid = 1'b0;
        chk("badface.roll_en", 8'(roll_en), 8'd1);
        chk("badface.rolls",   8'(rolls),   8'd0);
        chk("badface.sum",     8'(sum),     8'd2);
        chk("badface.state",   8'(state),   8'd1);
        for (int k = 1; k <= 15; k++) tick();
        chk("tmo15.roll_en", 8'(roll_en), 8'd0);
        tick();
        chk("tmo16.roll_en", 8'(roll_en), 8'd1);
        for (int k = 1; k <= 16; k++) tick();
        chk("tmo32.roll_en", 8'(roll_en), 8'd1);

        // Reset mid-wait with point 8
        throw_dice(3'd4, 3'd4);
        chk_outcome("pt8", 4'd8, 4'd8, 1'b0, 1'b0, 3'd2, 8'd1);
        press();
        tick();
        chk("pt8.wait", 8'(state), 8'd3);
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        chk_all_zero("midreset");
        die_a = 3'd4; die_b = 3'd4; die_valid = 1'b1;
        tick();
        die_valid = 1'b0;
        chk("postreset.state", 8'(state), 8'd0);
        chk("postreset.sum",   8'(sum),   8'd0);
        chk("postreset.rolls", 8'(rolls), 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/craps_round_ctrl.md
# craps_round_ctrl

Round controller for the craps game, directly downstream of the two die-face stages. It issues a one-cycle roll strobe to both die-face converters, captures their 1–6 faces, and sums them. It runs the come-out/point rules and holds the round outcome (win/lose, point, roll count) for the display and score logic.

## Interface
Parameters:
- TIMEOUT, default 15: cycles to wait for `die_valid` after a roll strobe before re-issuing it.

Ports:
- `clock` in 1: single system clock, rising edge.
- `resetn` in 1: synchronous active-low reset.
- `roll` in 1: roll request, one-cycle pulse from the debounced button.
- `die_a` in 3: face from die-face stage A; legal values 1..6.
- `die_b` in 3: face from die-face stage B; legal values 1..6.
- `die_valid` in 1: both faces are stable this cycle (one-cycle pulse).
- `roll_en` out 1: one-cycle strobe to both die-face stages' `clock_en`.
- `sum` out 4: last accepted dice total, 2..12.
- `point` out 4: established point; 0 when no point.
- `win` out 1: round won; held until the next round starts.
- `lose` out 1: round lost; held until the next round starts.
- `busy` out 1: high while waiting for dice.
- `state` out 3: FSM state code.
- `rolls` out 8: accepted rolls this round, saturating at 255.

## Operation
- States and codes: IDLE=0, WAIT_CO=1, POINT=2, WAIT_PT=3, WON=4, LOST=5.
- IDLE + `roll`: pulse `roll_en`, go to WAIT_CO.
- POINT + `roll`: pulse `roll_en`, go to WAIT_PT.
- WON/LOST + `roll`:
  - Start a new round: clear `win`, `lose`, `point`, `rolls`.
  - Pulse `roll_en`, go to WAIT_CO.
- `roll` in WAIT_CO or WAIT_PT is ignored.
- `die_valid` outside WAIT_CO/WAIT_PT is ignored; no output changes.
- In a wait state, `die_valid` with either face 0 or 7:
  - Discard the sample; `sum`, `rolls`, and state are unchanged.
  - Re-pulse `roll_en`; restart the timeout counter.
- Accepted roll: `sum = die_a + die_b`, zero-extended to 4 bits; `rolls` increments, saturating at 255.
- WAIT_CO outcome:
  - `sum` of 7 or 11 → WON, `win`=1.
  - `sum` of 2, 3 or 12 → LOST, `lose`=1.
  - Otherwise `point = sum` → POINT.
- WAIT_PT outcome:
  - `sum == point` → WON, `win`=1.
  - Else `sum == 7` → LOST, `lose`=1.
  - Else → POINT, `point` unchanged.
- Timeout: a wait state with no `die_valid` for TIMEOUT cycles after `roll_en` re-pulses `roll_en` and restarts the count. Retries are unlimited.
- `win` and `lose` are never both 1.
- `busy` = (state == WAIT_CO or WAIT_PT).

## Timing
- Reset: `resetn` low at a rising edge forces IDLE. All outputs are 0 on the following cycle: `roll_en`, `sum`, `point`, `win`, `lose`, `busy`, `state`, `rolls`.
- Reset mid-wait discards the pending roll. A later `die_valid` is ignored, because the FSM is in IDLE.
- `roll` sampled at edge N: `roll_en`=1 for exactly cycle N+1, and `state`/`busy` update at N+1.
- `die_valid` is honoured from cycle N+2 onward. A `die_valid` coincident with `roll_en` (cycle N+1) is ignored.
- `die_valid` sampled at edge M in a wait state: `sum`, `rolls`, `point`, `win`, `lose`, `state` all update together at M+1.
- Invalid-face retry: `roll_en`=1 at M+1.
- Timeout: counter loads 0 in the `roll_en` cycle and increments each wait cycle. On reaching TIMEOUT, `roll_en`=1 on the next cycle, i.e. `roll_en` repeats every TIMEOUT+1 cycles while no `die_valid` arrives.
- `roll_en` is registered and never asserted on two consecutive cycles.
- All outputs are registered; no combinational input-to-output paths.

## Test plan
- Natural win: reset, `roll`, then `die_valid` with a=3, b=4 → `sum`=7, `win`=1, `state`=4, `rolls`=1, `point`=0.
- Point made:
  - Come-out a=2, b=2 → `point`=4, `state`=2.
  - Roll a=5, b=1 → `sum`=6, `state`=2.
  - Roll a=1, b=3 → `win`=1, `state`=4, `rolls`=3.
- Seven-out: come-out a=5, b=5 (`point`=10), then a=6, b=1 → `lose`=1, `state`=5, `point` stays 10. Next `roll` → `lose`=0, `point`=0, `rolls`=0, `state`=1.
- Craps on come-out: a=6, b=6 → `lose`=1, `sum`=12. Also a=1, b=1 → `lose`=1.
- Robustness:
  - Invalid face a=7 → `rolls` unchanged and `roll_en` re-pulses one cycle later.
  - With TIMEOUT=15 and no `die_valid`, `roll_en` pulses every 16 cycles.
  - `roll` during WAIT_CO produces no extra `roll_en`.
- Reset mid-wait: `resetn`=0 in WAIT_PT with `point`=8 → all outputs 0 next cycle. A following `die_valid` (a=4, b=4) leaves `state`=0 and `sum`=0.
